// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory.
// Optional trailer checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] NUM        = 32'h0000_4000,
  parameter logic [31:0] BASE_WORD  = 32'h0000_0C00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           words_written
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR, S_LOAD, S_WRITE, S_CHK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_HDR, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;
`endif

  localparam logic [31:0] MAX_WORDS = NUM - BASE_WORD;

  state_t                state_q, state_d;
  logic [31:0]           count_q, count_d;
  logic [23:0]           asm_q, asm_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [31:0]           ww_q, ww_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
`endif

  logic                  accept;
  logic                  last_byte;
  logic [31:0]           shifted;
  logic [31:0]           hdr_word;
  logic [ADDR_WIDTH-1:0] word_addr;

  always_comb begin
    accept    = in_valid && in_ready_q;
    last_byte = accept && (bcnt_q == 2'd3);
    shifted   = {asm_q, in_data};
    hdr_word  = {count_q[23:0], in_data};
    word_addr = ADDR_WIDTH'((BASE_WORD + ww_q) << 2);

    state_d     = state_q;
    count_d     = count_q;
    asm_d       = asm_q;
    bcnt_d      = accept ? bcnt_q + 2'd1 : bcnt_q;
    ww_d        = ww_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      S_HDR: begin
        if (accept) begin
          count_d = hdr_word;
          if (last_byte) begin
            if (hdr_word > MAX_WORDS) begin
              state_d = S_ERR;
            end else if (hdr_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          asm_d = shifted[23:0];
          if (last_byte) begin
            state_d     = S_WRITE;
            mem_addr_d  = word_addr;
            mem_wdata_d = WIDTH'(shifted);
          end
        end
      end
      S_WRITE: begin
        ww_d = ww_q + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d = sum_q + 32'(mem_wdata_q);
        state_d = (ww_d == count_q) ? S_CHK : S_LOAD;
`else
        state_d = (ww_d == count_q) ? S_DONE : S_LOAD;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          asm_d = shifted[23:0];
          if (last_byte) begin
            state_d = (shifted == sum_q) ? S_DONE : S_ERR;
          end
        end
      end
`endif
      default: state_d = state_q;
    endcase

    // Outputs are registered images of the next state, so they line up with it.
    in_ready_d = (state_d == S_HDR) || (state_d == S_LOAD)
`ifdef IMEM_LOADER_CHECKSUM_EN
                 || (state_d == S_CHK)
`endif
                 ;
    mem_we_d   = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      count_q     <= '0;
      asm_q       <= '0;
      bcnt_q      <= '0;
      ww_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      asm_q       <= asm_d;
      bcnt_q      <= bcnt_d;
      ww_q        <= ww_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = ww_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive word slots starting at word index 0x0C00 (byte address 0x0000_3000). While loading, it holds the CPU in reset, and it releases the CPU only when loading has completed. It replaces file-based preload with a runtime load path and sits between the host byte link and the write port of the instruction memory.

## Interface
- `WIDTH`, 32, instruction word width.
- `ADDR_WIDTH`, 32, width of the memory byte address.
- `NUM`, 32'h0000_4000, memory depth in words.
- `BASE_WORD`, 32'h0000_0C00, word index of the first word written.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a byte is offered on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  one-cycle write strobe to the instruction memory.
- `mem_addr`  out  ADDR_WIDTH  byte address of the write; always word-aligned.
- `mem_wdata`  out  WIDTH  word to write.
- `cpu_hold`  out  1  keeps the CPU in reset while high.
- `done`  out  1  load finished successfully; sticky.
- `error`  out  1  load aborted; sticky.
- `words_written`  out  32  count of words written so far.

## Operation
- **Byte transfer:** a byte transfers on a cycle where `in_valid && in_ready`. No other cycle consumes a byte.
- **Stream format:**
  - 4-byte header N, the word count, most significant byte first.
  - N words, each 4 bytes, most significant byte first.
  - With the checksum enabled, a 4-byte trailer follows.
- **HDR:** `in_ready`=1. The loader shifts bytes into the count register.
  - On the 4th byte, if N==0 (with the checksum disabled) it goes to DONE.
  - If N > NUM-BASE_WORD it goes to ERR and performs no writes.
  - Otherwise it goes to LOAD.
- **LOAD:** `in_ready`=1. The loader shifts bytes into the word assembler (new byte enters at bits [7:0]). On the 4th byte it goes to WRITE.
- **WRITE:** `in_ready`=0 and `mem_we`=1.
  - `mem_addr` = (BASE_WORD + `words_written`) << 2.
  - `mem_wdata` = the assembled word.
  - On the next edge `words_written` increments.
  - If the incremented count equals N, the loader goes to DONE (or CHK when the checksum is enabled). Otherwise it returns to LOAD.
- **DONE:** `in_ready`=0, `done`=1, `cpu_hold`=0. Terminal until `rst`.
- **ERR:** `in_ready`=0, `error`=1, `cpu_hold`=1. Terminal until `rst`.
- **Byte counter:** the byte counter within the header, word or trailer is 2 bits wide and wraps from 3 to 0 on each 4th byte.
- **Address arithmetic:** addresses are computed modulo 2^ADDR_WIDTH. Given the range check, the highest word written is NUM-1.
- **Stalls:** `in_valid` low stalls indefinitely with no state change. Bytes offered while `in_ready`=0 are not consumed, and the source must hold them.

## Timing
- **Reset values** (`rst` high at an edge):
  - state=HDR, `in_ready`=1, `mem_we`=0.
  - `mem_addr`=0, `mem_wdata`=0.
  - `cpu_hold`=1, `done`=0, `error`=0.
  - `words_written`=0, and the count, assembler and byte counter are cleared.
- **Write latency:** the 4th byte of a word accepted at edge t gives `mem_we`=1 during cycle t+1. The next byte can be accepted at edge t+2. Minimum cost is 5 cycles per word.
- **Completion latency:** after the last write (checksum disabled), `done` and `cpu_hold`=0 are asserted in the cycle following the write cycle.
- **Mid-load reset:** `rst` asserted mid-load aborts immediately. Words already written remain in memory, and the next byte accepted is treated as header byte 0.
- **Reset and write together:** if `rst` and a pending WRITE coincide, `rst` wins. No strobe is issued after that edge.

## Configuration
- **`IMEM_LOADER_CHECKSUM_EN` defined:**
  - After the N-th write the loader enters CHK (`in_ready`=1) and accepts a 4-byte big-endian trailer.
  - The trailer is compared with the running 32-bit sum (mod 2^32) of all written words.
  - On a match it goes to DONE, and on a mismatch it goes to ERR.
  - With N==0, the loader goes from HDR to CHK and expects a trailer of 0.
- **Not defined:** there is no CHK state and no trailer is consumed. The loader goes to DONE after the N-th write, or directly from HDR when N==0.

## Test plan
- **Two-word load:** stream 00 00 00 02, 24 08 00 05, 00 00 00 0C (macro off) → writes 0x2408_0005 at 0x3000 and 0x0000_000C at 0x3004; `done`=1; `cpu_hold`=0; `words_written`=2.
- **Zero-length load:** header 00 00 00 00 → `done` in the cycle after the 4th byte with no `mem_we` pulse; with the macro on, a trailer of 00 00 00 00 is required first.
- **Oversize header:** header 0x0000_3401 with default parameters → `error`=1, zero writes, `cpu_hold` stays 1, `in_ready`=0.
- **Handshake stalls:** randomly gap `in_valid` during the two-word load → identical writes; `in_ready` low exactly during each write cycle; no byte lost or duplicated.
- **Reset mid-load:** assert `rst` after 6 bytes, then send a fresh one-word stream 00 00 00 01, DE AD BE EF → a single write of 0xDEAD_BEEF at 0x3000.
- **Checksum** (macro on): two words 0x0000_0001 and 0xFFFF_FFFF with trailer 00 00 00 00 → `done`. The same words with trailer 00 00 00 01 → `error`=1 after both writes.
